// File: rtl/multicycle_control.sv
// Multi-cycle MIPS instruction sequencer: steps each instruction through
// fetch/decode/execute/memory/write-back and drives the shared datapath strobes.
module multicycle_control #(
  parameter logic [3:0] ADD_CODE = 4'b0000,
  parameter logic [3:0] SUB_CODE = 4'b0001,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic [3:0]       alu_code,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       pc_src,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_ctl,
  output logic [3:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    HALT   = 4'd10
  } state_t;

  state_t cur_state;
  state_t next_state;
  logic   illegal_set;
  logic   retire;

  logic is_rtype, rtype_ok, is_ialu, is_lw, is_sw, is_beq, is_j, is_halt;

  assign is_rtype = (opcode == 6'b000000);
  assign rtype_ok = (func == 6'b000001) || (func == 6'b000011) ||
                    ((func >= 6'b000100) && (func <= 6'b001010));
  assign is_ialu  = (opcode >= 6'b000001) && (opcode <= 6'b000100);
  assign is_lw    = (opcode == 6'b100011);
  assign is_sw    = (opcode == 6'b101011);
  assign is_beq   = (opcode == 6'b000101);
  assign is_j     = (opcode == 6'b000110);
  assign is_halt  = (opcode == 6'b111111);

  assign state  = cur_state;
  assign halted = (cur_state == HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= FETCH;
      instr_cnt <= '0;
      illegal   <= 1'b0;
    end else begin
      cur_state <= next_state;
      if (retire)
        instr_cnt <= instr_cnt + CNT_W'(1);
      if (illegal_set)
        illegal <= 1'b1;
    end
  end

  always_comb begin
    next_state  = cur_state;
    illegal_set = 1'b0;
    retire      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    pc_src      = 2'd0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    alu_ctl     = 4'b0000;
    case (cur_state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        alu_ctl   = ADD_CODE;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)
          next_state = DECODE;
      end
      DECODE: begin
        // ALUOut captures the branch target speculatively while the opcode is classified
        alu_src_b = 2'd3;
        alu_ctl   = ADD_CODE;
        if ((is_rtype && rtype_ok) || is_ialu) next_state = EXEC;
        else if (is_lw || is_sw)               next_state = MEMADR;
        else if (is_beq)                       next_state = BRANCH;
        else if (is_j)                         next_state = JUMP;
        else if (is_halt)                      next_state = HALT;
        else begin
          next_state  = HALT;
          illegal_set = 1'b1;
        end
      end
      EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = is_rtype ? 2'd0 : 2'd2;
        alu_ctl    = alu_code;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype;
        retire     = 1'b1;
        next_state = FETCH;
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        alu_ctl    = ADD_CODE;
        next_state = is_sw ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready)
          next_state = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = FETCH;
        end
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctl    = SUB_CODE;
        pc_src     = 2'd1;
        pc_write   = zero;
        retire     = 1'b1;
        next_state = FETCH;
      end
      JUMP: begin
        pc_src     = 2'd2;
        pc_write   = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      HALT: next_state = HALT;
      default: next_state = FETCH;
    endcase
    // Strobes must not reach memory or state elements while reset is held
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence with hand-computed expected strobes and counter values.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] func;
  logic [3:0] alu_code;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write;
  logic [1:0] pc_src;
  logic       reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_ctl;
  logic [3:0] state;
  logic       halted, illegal;
  logic [3:0] instr_cnt;

  int check_count = 0;
  int pass_count  = 0;

  multicycle_control #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func),
    .alu_code(alu_code), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl),
    .state(state), .halted(halted), .illegal(illegal), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rdy, input logic z, input logic [5:0] op,
                               input logic [5:0] fn, input logic [3:0] ac);
    mem_ready = rdy;
    zero      = z;
    opcode    = op;
    func      = fn;
    alu_code  = ac;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 6'h00, 6'h00, 4'h0);
    tick();
    tick();
    checkOutput("rst_state", 32'(state), 0);
    checkOutput("rst_cnt", 32'(instr_cnt), 0);
    checkOutput("rst_mem_req", 32'(mem_req), 0);
    checkOutput("rst_illegal", 32'(illegal), 0);
    checkOutput("rst_halted", 32'(halted), 0);

    // R-type, func=000001
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 6'h00, 6'h01, 4'h0);
    checkOutput("r_fetch_mem_req", 32'(mem_req), 1);
    checkOutput("r_fetch_ir_write", 32'(ir_write), 1);
    checkOutput("r_fetch_pc_write", 32'(pc_write), 1);
    checkOutput("r_fetch_alu_src_b", 32'(alu_src_b), 1);
    checkOutput("r_fetch_alu_ctl", 32'(alu_ctl), 0);
    tick();
    checkOutput("r_decode_state", 32'(state), 1);
    checkOutput("r_decode_alu_src_b", 32'(alu_src_b), 3);
    tick();
    checkOutput("r_exec_state", 32'(state), 6);
    checkOutput("r_exec_alu_src_a", 32'(alu_src_a), 1);
    checkOutput("r_exec_alu_src_b", 32'(alu_src_b), 0);
    tick();
    checkOutput("r_aluwb_state", 32'(state), 7);
    checkOutput("r_aluwb_reg_write", 32'(reg_write), 1);
    checkOutput("r_aluwb_reg_dst", 32'(reg_dst), 1);
    tick();
    checkOutput("r_done_state", 32'(state), 0);
    checkOutput("r_done_cnt", 32'(instr_cnt), 1);

    // LW with two wait cycles in MEMRD
    applyStimulus(1'b1, 1'b0, 6'h23, 6'h00, 4'h0);
    tick();
    tick();
    checkOutput("lw_memadr_state", 32'(state), 2);
    checkOutput("lw_memadr_alu_src_b", 32'(alu_src_b), 2);
    tick();
    applyStimulus(1'b0, 1'b0, 6'h23, 6'h00, 4'h0);
    checkOutput("lw_memrd0_state", 32'(state), 3);
    checkOutput("lw_memrd0_mem_req", 32'(mem_req), 1);
    checkOutput("lw_memrd0_i_or_d", 32'(i_or_d), 1);
    checkOutput("lw_memrd0_mem_we", 32'(mem_we), 0);
    tick();
    checkOutput("lw_memrd1_state", 32'(state), 3);
    checkOutput("lw_memrd1_mem_req", 32'(mem_req), 1);
    checkOutput("lw_memrd1_i_or_d", 32'(i_or_d), 1);
    tick();
    applyStimulus(1'b1, 1'b0, 6'h23, 6'h00, 4'h0);
    checkOutput("lw_memrd2_state", 32'(state), 3);
    checkOutput("lw_memrd2_mem_req", 32'(mem_req), 1);
    tick();
    checkOutput("lw_memwb_state", 32'(state), 4);
    checkOutput("lw_memwb_reg_write", 32'(reg_write), 1);
    checkOutput("lw_memwb_mem_to_reg", 32'(mem_to_reg), 1);
    tick();
    checkOutput("lw_done_state", 32'(state), 0);
    checkOutput("lw_done_cnt", 32'(instr_cnt), 2);

    // BEQ taken
    applyStimulus(1'b1, 1'b1, 6'h05, 6'h00, 4'h0);
    tick();
    tick();
    checkOutput("beq1_state", 32'(state), 8);
    checkOutput("beq1_pc_write", 32'(pc_write), 1);
    checkOutput("beq1_pc_src", 32'(pc_src), 1);
    checkOutput("beq1_alu_ctl", 32'(alu_ctl), 1);
    tick();
    checkOutput("beq1_done_cnt", 32'(instr_cnt), 3);

    // BEQ not taken
    applyStimulus(1'b1, 1'b0, 6'h05, 6'h00, 4'h0);
    tick();
    tick();
    checkOutput("beq0_pc_write", 32'(pc_write), 0);
    tick();
    checkOutput("beq0_done_state", 32'(state), 0);
    checkOutput("beq0_done_cnt", 32'(instr_cnt), 4);

    // J
    applyStimulus(1'b1, 1'b0, 6'h06, 6'h00, 4'h0);
    tick();
    tick();
    checkOutput("j_state", 32'(state), 9);
    checkOutput("j_pc_write", 32'(pc_write), 1);
    checkOutput("j_pc_src", 32'(pc_src), 2);
    tick();
    checkOutput("j_done_cnt", 32'(instr_cnt), 5);

    // I-type ALU with pass-through ALU code
    applyStimulus(1'b1, 1'b0, 6'h02, 6'h00, 4'h6);
    tick();
    tick();
    checkOutput("iall_exec_state", 32'(state), 6);
    checkOutput("iall_exec_alu_src_b", 32'(alu_src_b), 2);
    checkOutput("iall_exec_alu_ctl", 32'(alu_ctl), 6);
    tick();
    checkOutput("iall_aluwb_reg_write", 32'(reg_write), 1);
    checkOutput("iall_aluwb_reg_dst", 32'(reg_dst), 0);
    tick();
    checkOutput("iall_done_cnt", 32'(instr_cnt), 6);

    // SW abandoned by reset while its request is outstanding
    applyStimulus(1'b1, 1'b0, 6'h2B, 6'h00, 4'h0);
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 6'h2B, 6'h00, 4'h0);
    checkOutput("sw_memwr_state", 32'(state), 5);
    checkOutput("sw_memwr_mem_req", 32'(mem_req), 1);
    checkOutput("sw_memwr_mem_we", 32'(mem_we), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("sw_rst_mem_req", 32'(mem_req), 0);
    checkOutput("sw_rst_mem_we", 32'(mem_we), 0);
    tick();
    checkOutput("sw_rst_state", 32'(state), 0);
    checkOutput("sw_rst_cnt", 32'(instr_cnt), 0);

    // Counter wrap: 17 jumps on a 4-bit counter
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 6'h06, 6'h00, 4'h0);
    for (int i = 0; i < 17; i++) begin
      repeat (3) tick();
    end
    checkOutput("wrap_state", 32'(state), 0);
    checkOutput("wrap_cnt", 32'(instr_cnt), 1);

    // HALT instruction: halted but not illegal, not counted
    applyStimulus(1'b1, 1'b0, 6'h3F, 6'h00, 4'h0);
    tick();
    tick();
    checkOutput("halt_state", 32'(state), 10);
    checkOutput("halt_halted", 32'(halted), 1);
    checkOutput("halt_illegal", 32'(illegal), 0);
    checkOutput("halt_cnt", 32'(instr_cnt), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("halt_rst_halted", 32'(halted), 0);
    checkOutput("halt_rst_state", 32'(state), 0);

    // Illegal opcode
    applyStimulus(1'b1, 1'b0, 6'h1F, 6'h00, 4'h0);
    tick();
    tick();
    checkOutput("illop_state", 32'(state), 10);
    checkOutput("illop_illegal", 32'(illegal), 1);
    checkOutput("illop_halted", 32'(halted), 1);
    checkOutput("illop_mem_req", 32'(mem_req), 0);
    tick();
    tick();
    checkOutput("illop_stuck_state", 32'(state), 10);
    checkOutput("illop_stuck_ir_write", 32'(ir_write), 0);
    checkOutput("illop_stuck_pc_write", 32'(pc_write), 0);
    checkOutput("illop_stuck_reg_write", 32'(reg_write), 0);

    // Illegal R-type func
    rst_n = 1'b0;
    tick();
    checkOutput("illfn_rst_illegal", 32'(illegal), 0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 6'h00, 6'h02, 4'h0);
    tick();
    tick();
    checkOutput("illfn_state", 32'(state), 10);
    checkOutput("illfn_illegal", 32'(illegal), 1);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
